// File: rtl/sent_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sent_tx_pkg
// Brief    : SENT transmit CRC mode/done codes, mode-to-done mapping, arbiter FSM states
// Revision : 1.0 - initial release
// ============================================================================
package sent_tx_pkg;

  localparam logic [2:0] C_MODE_NONE    = 3'b000;
  localparam logic [2:0] C_MODE_FAST24  = 3'b001;
  localparam logic [2:0] C_MODE_FAST16  = 3'b010;
  localparam logic [2:0] C_MODE_FAST12  = 3'b011;
  localparam logic [2:0] C_MODE_SHORT12 = 3'b100;
  localparam logic [2:0] C_MODE_ENH24   = 3'b101;

  localparam logic [1:0] C_DONE_NONE  = 2'b00;
  localparam logic [1:0] C_DONE_FAST  = 2'b01;
  localparam logic [1:0] C_DONE_SHORT = 2'b10;
  localparam logic [1:0] C_DONE_ENH   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_RESP  = 2'd2,
    ST_FAULT = 2'd3
  } arb_state_e;

  // Completion code the generator reports for a given mode; NONE for illegal modes.
  function automatic logic [1:0] mode_to_done(input logic [2:0] mode);
    case (mode)
      C_MODE_FAST24, C_MODE_FAST16, C_MODE_FAST12: return C_DONE_FAST;
      C_MODE_SHORT12:                              return C_DONE_SHORT;
      C_MODE_ENH24:                                return C_DONE_ENH;
      default:                                     return C_DONE_NONE;
    endcase
  endfunction

  function automatic logic fast_mode_legal(input logic [2:0] mode);
    return (mode == C_MODE_FAST24) || (mode == C_MODE_FAST16) || (mode == C_MODE_FAST12);
  endfunction

  function automatic logic slow_mode_legal(input logic [2:0] mode);
    return (mode == C_MODE_SHORT12) || (mode == C_MODE_ENH24);
  endfunction

  function automatic logic crc_is_6bit(input logic [2:0] mode);
    return (mode == C_MODE_ENH24);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sent_tx_crc_arb.sv
`default_nettype none
// ============================================================================
// Module   : sent_tx_crc_arb
// Brief    : Round-robin arbiter sharing one SENT CRC generator between the
//            fast-channel and slow-serial frame builders, with busy timeout.
// Revision : 1.0 - initial release
// ============================================================================
module sent_tx_crc_arb
  import sent_tx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 128
) (
  input  logic        clk_tx,
  input  logic        reset_n_tx,
  input  logic        fast_req_i,
  input  logic [2:0]  fast_mode_i,
  input  logic [23:0] fast_data_i,
  output logic        fast_ack_o,
  input  logic        slow_req_i,
  input  logic [2:0]  slow_mode_i,
  input  logic [23:0] slow_data_i,
  output logic        slow_ack_o,
  output logic [5:0]  crc_o,
  output logic        crc_err_o,
  output logic        fault_o,
  output logic [2:0]  enable_crc_gen_o,
  output logic [23:0] data_gen_crc_o,
  input  logic [5:0]  crc_gen_i,
  input  logic [1:0]  crc_gen_done_i
);

  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_e  r_state;
  logic        r_ptr_slow;
  logic        r_owner_slow;
  logic [2:0]  r_mode;
  logic [7:0]  r_count;
  logic [2:0]  r_enable;
  logic [23:0] r_data;
  logic [5:0]  r_crc;
  logic        r_crc_err;
  logic        r_fast_ack;
  logic        r_slow_ack;
  logic        r_fault;

  logic        w_any_req;
  logic        w_grant_slow;
  logic [2:0]  w_gnt_mode;
  logic [23:0] w_gnt_data;
  logic        w_gnt_legal;
  logic        w_done_match;
  logic [5:0]  w_crc_masked;

  // Slow wins only when it is alone or the pointer favours it.
  assign w_any_req    = fast_req_i | slow_req_i;
  assign w_grant_slow = slow_req_i & (~fast_req_i | r_ptr_slow);
  assign w_gnt_mode   = w_grant_slow ? slow_mode_i : fast_mode_i;
  assign w_gnt_data   = w_grant_slow ? slow_data_i : fast_data_i;
  assign w_gnt_legal  = w_grant_slow ? slow_mode_legal(slow_mode_i)
                                     : fast_mode_legal(fast_mode_i);
  assign w_done_match = (crc_gen_done_i == mode_to_done(r_mode));
  assign w_crc_masked = crc_is_6bit(r_mode) ? crc_gen_i : {2'b00, crc_gen_i[3:0]};

  always_ff @(posedge clk_tx) begin
    if (!reset_n_tx) begin
      r_state      <= ST_IDLE;
      r_ptr_slow   <= 1'b0;
      r_owner_slow <= 1'b0;
      r_mode       <= C_MODE_NONE;
      r_count      <= 8'd0;
      r_enable     <= C_MODE_NONE;
      r_data       <= 24'd0;
      r_crc        <= 6'd0;
      r_crc_err    <= 1'b0;
      r_fast_ack   <= 1'b0;
      r_slow_ack   <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_fast_ack <= 1'b0;
      r_slow_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_enable <= C_MODE_NONE;
          if (w_any_req) begin
            r_owner_slow <= w_grant_slow;
            r_ptr_slow   <= ~w_grant_slow;
            r_mode       <= w_gnt_mode;
            if (w_gnt_legal) begin
              r_enable <= w_gnt_mode;
              r_data   <= w_gnt_data;
              r_count  <= 8'd0;
              r_state  <= ST_BUSY;
            end else begin
              r_crc      <= 6'd0;
              r_crc_err  <= 1'b1;
              r_fast_ack <= ~w_grant_slow;
              r_slow_ack <= w_grant_slow;
              r_state    <= ST_RESP;
            end
          end
        end

        ST_BUSY: begin
          r_count <= r_count + 8'd1;
          if (crc_gen_done_i != C_DONE_NONE) begin
            r_crc      <= w_crc_masked;
            r_crc_err  <= ~w_done_match;
            r_fast_ack <= ~r_owner_slow;
            r_slow_ack <= r_owner_slow;
            r_enable   <= C_MODE_NONE;
            r_state    <= ST_RESP;
          end else if (r_count == C_TIMEOUT_LAST) begin
            r_fault    <= 1'b1;
            r_crc      <= 6'd0;
            r_crc_err  <= 1'b1;
            r_fast_ack <= ~r_owner_slow;
            r_slow_ack <= r_owner_slow;
            r_enable   <= C_MODE_NONE;
            r_state    <= ST_FAULT;
          end
        end

        ST_RESP: begin
          r_enable <= C_MODE_NONE;
          r_state  <= ST_IDLE;
        end

        ST_FAULT: begin
          // An ack still high means its requester has not yet seen it; skip that cycle.
          r_enable <= C_MODE_NONE;
          if (w_any_req && !r_fast_ack && !r_slow_ack) begin
            r_ptr_slow <= ~w_grant_slow;
            r_crc      <= 6'd0;
            r_crc_err  <= 1'b1;
            r_fast_ack <= ~w_grant_slow;
            r_slow_ack <= w_grant_slow;
          end
        end

        default: begin
          r_enable <= C_MODE_NONE;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign fast_ack_o       = r_fast_ack;
  assign slow_ack_o       = r_slow_ack;
  assign crc_o            = r_crc;
  assign crc_err_o        = r_crc_err;
  assign fault_o          = r_fault;
  assign enable_crc_gen_o = r_enable;
  assign data_gen_crc_o   = r_data;

endmodule
`default_nettype wire

// File: tb/tb_sent_tx_crc_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sent_tx_crc_arb
// Brief    : Scoreboard bench for sent_tx_crc_arb with a behavioural CRC generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sent_tx_crc_arb;

  localparam int TIMEOUT = 128;

  logic        clk_tx = 1'b0;
  logic        reset_n_tx;
  logic        fast_req_i, slow_req_i;
  logic [2:0]  fast_mode_i, slow_mode_i;
  logic [23:0] fast_data_i, slow_data_i;
  logic        fast_ack_o, slow_ack_o;
  logic [5:0]  crc_o;
  logic        crc_err_o, fault_o;
  logic [2:0]  enable_crc_gen_o;
  logic [23:0] data_gen_crc_o;
  logic [5:0]  crc_gen_i;
  logic [1:0]  crc_gen_done_i;

  always #5 clk_tx = ~clk_tx;

  sent_tx_crc_arb #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_tx(clk_tx), .reset_n_tx(reset_n_tx),
    .fast_req_i(fast_req_i), .fast_mode_i(fast_mode_i), .fast_data_i(fast_data_i),
    .fast_ack_o(fast_ack_o),
    .slow_req_i(slow_req_i), .slow_mode_i(slow_mode_i), .slow_data_i(slow_data_i),
    .slow_ack_o(slow_ack_o),
    .crc_o(crc_o), .crc_err_o(crc_err_o), .fault_o(fault_o),
    .enable_crc_gen_o(enable_crc_gen_o), .data_gen_crc_o(data_gen_crc_o),
    .crc_gen_i(crc_gen_i), .crc_gen_done_i(crc_gen_done_i)
  );

  typedef struct {
    bit          slow;
    logic [2:0]  mode;
    logic [23:0] data;
    bit          use_gen;
    logic [5:0]  crc;
    bit          err;
    bit          check_crc;
    int          lat;      // 0 none, 1 one cycle after done, 2 one cycle after grant
  } exp_t;

  exp_t sb[$];

  int         errors = 0;
  int         checks = 0;
  int         gen_delay = 2;
  logic [1:0] gen_force_done = 2'b00;
  bit         gen_silent = 1'b0;
  logic [5:0] gen_crc = 6'h0A;
  int         last_done_cyc = -10;
  int         last_busy_cnt = 0;

  task automatic tick();
    @(posedge clk_tx);
    #1;
  endtask

  function automatic logic [1:0] model_done(input logic [2:0] m);
    case (m)
      3'b001, 3'b010, 3'b011: return 2'b01;
      3'b100:                 return 2'b10;
      3'b101:                 return 2'b11;
      default:                return 2'b00;
    endcase
  endfunction

  task automatic apply_reset();
    reset_n_tx     = 1'b0;
    fast_req_i     = 1'b0;
    slow_req_i     = 1'b0;
    crc_gen_done_i = 2'b00;
    sb.delete();
    tick();
    tick();
    reset_n_tx = 1'b1;
    tick();
  endtask

  task automatic request(input bit slow, input logic [2:0] mode, input logic [23:0] data,
                         input bit use_gen, input logic [5:0] crc, input bit err,
                         input bit check_crc, input int lat);
    exp_t e;
    e.slow = slow; e.mode = mode; e.data = data; e.use_gen = use_gen;
    e.crc = crc; e.err = err; e.check_crc = check_crc; e.lat = lat;
    if (slow) begin
      slow_req_i = 1'b1; slow_mode_i = mode; slow_data_i = data;
    end else begin
      fast_req_i = 1'b1; fast_mode_i = mode; fast_data_i = data;
    end
    sb.push_back(e);
  endtask

  // Runs the generator model and pops the scoreboard on every ack.
  task automatic service(input int max_cycles);
    int   cyc  = 0;
    int   gcnt = 0;
    exp_t e;
    while ((sb.size() != 0 || fast_req_i || slow_req_i) && cyc < max_cycles) begin
      tick();
      crc_gen_done_i = 2'b00;
      checks++;
      if (fast_ack_o && slow_ack_o) begin
        errors++;
        $display("FAIL both_acks: fast=%b slow=%b, required not both high", fast_ack_o, slow_ack_o);
      end
      if (fast_ack_o || slow_ack_o) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_ack: fast=%b slow=%b with nothing outstanding", fast_ack_o, slow_ack_o);
        end else begin
          e = sb.pop_front();
          checks++;
          if (slow_ack_o !== e.slow) begin
            errors++;
            $display("FAIL ack_owner: slow_ack=%b, required %b", slow_ack_o, e.slow);
          end
          checks++;
          if (crc_err_o !== e.err) begin
            errors++;
            $display("FAIL crc_err: got %b, required %b (mode %b)", crc_err_o, e.err, e.mode);
          end
          if (e.check_crc) begin
            checks++;
            if (crc_o !== e.crc) begin
              errors++;
              $display("FAIL crc_value: got %h, required %h (mode %b)", crc_o, e.crc, e.mode);
            end
          end
          if (e.lat == 1) begin
            checks++;
            if (cyc !== last_done_cyc + 1) begin
              errors++;
              $display("FAIL done_latency: ack at cycle %0d, required %0d", cyc, last_done_cyc + 1);
            end
          end else if (e.lat == 2) begin
            checks++;
            if (cyc !== 0) begin
              errors++;
              $display("FAIL grant_latency: ack at cycle %0d, required 0", cyc);
            end
          end
        end
        last_busy_cnt = gcnt;
        gcnt = 0;
        if (slow_ack_o) slow_req_i = 1'b0;
        else            fast_req_i = 1'b0;
      end else if (enable_crc_gen_o !== 3'b000) begin
        gcnt++;
        checks++;
        if (sb.size() == 0 || !sb[0].use_gen) begin
          errors++;
          $display("FAIL enable_leak: enable=%b, required 000", enable_crc_gen_o);
        end else if (enable_crc_gen_o !== sb[0].mode || data_gen_crc_o !== sb[0].data) begin
          errors++;
          $display("FAIL gen_drive: enable=%b data=%h, required %b %h",
                   enable_crc_gen_o, data_gen_crc_o, sb[0].mode, sb[0].data);
        end
        if (!gen_silent && gcnt == gen_delay) begin
          crc_gen_done_i = (gen_force_done != 2'b00) ? gen_force_done : model_done(enable_crc_gen_o);
          crc_gen_i      = gen_crc;
          last_done_cyc  = cyc;
        end
      end
      cyc++;
    end
    checks++;
    if (sb.size() != 0 || fast_req_i || slow_req_i) begin
      errors++;
      $display("FAIL service_timeout: %0d jobs outstanding after %0d cycles, required 0", sb.size(), cyc);
      sb.delete();
      fast_req_i = 1'b0;
      slow_req_i = 1'b0;
    end
    tick();
    checks++;
    if (fast_ack_o || slow_ack_o || enable_crc_gen_o !== 3'b000) begin
      errors++;
      $display("FAIL ack_width: fast=%b slow=%b enable=%b one cycle after ack, required 0/0/000",
               fast_ack_o, slow_ack_o, enable_crc_gen_o);
    end
  endtask

  task automatic test_reset();
    reset_n_tx = 1'b0;
    tick();
    tick();
    checks++;
    if ({fast_ack_o, slow_ack_o, crc_o, crc_err_o, fault_o, enable_crc_gen_o, data_gen_crc_o} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b%b crc=%h err=%b fault=%b en=%b data=%h, required all 0",
               fast_ack_o, slow_ack_o, crc_o, crc_err_o, fault_o, enable_crc_gen_o, data_gen_crc_o);
    end
    reset_n_tx = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    gen_crc = 6'h0A; gen_delay = 3;
    request(1'b0, 3'b001, 24'h123456, 1'b1, 6'h0A, 1'b0, 1'b1, 1);
    service(50);
    gen_crc = 6'h35; gen_delay = 1;
    request(1'b1, 3'b100, 24'h000ABC, 1'b1, 6'h05, 1'b0, 1'b1, 1);
    service(50);
  endtask

  task automatic test_round_robin();
    apply_reset();
    gen_crc = 6'h3A; gen_delay = 2;
    request(1'b0, 3'b010, 24'h00ABCD, 1'b1, 6'h0A, 1'b0, 1'b1, 1);
    request(1'b1, 3'b101, 24'h654321, 1'b1, 6'h3A, 1'b0, 1'b1, 1);
    service(80);
    gen_crc = 6'h27; gen_delay = 4;
    request(1'b0, 3'b011, 24'h000FED, 1'b1, 6'h07, 1'b0, 1'b1, 1);
    request(1'b1, 3'b100, 24'h000321, 1'b1, 6'h07, 1'b0, 1'b1, 1);
    service(80);
  endtask

  task automatic test_mismatch();
    gen_force_done = 2'b01; gen_delay = 2;
    request(1'b1, 3'b101, 24'hA5A5A5, 1'b1, 6'h00, 1'b1, 1'b0, 1);
    service(50);
    gen_force_done = 2'b11;
    request(1'b0, 3'b010, 24'h00BEEF, 1'b1, 6'h00, 1'b1, 1'b0, 1);
    service(50);
    gen_force_done = 2'b00;
  endtask

  task automatic test_illegal();
    request(1'b0, 3'b100, 24'h111111, 1'b0, 6'h00, 1'b1, 1'b1, 2);
    service(20);
    request(1'b1, 3'b110, 24'h222222, 1'b0, 6'h00, 1'b1, 1'b1, 2);
    service(20);
    request(1'b0, 3'b000, 24'h333333, 1'b0, 6'h00, 1'b1, 1'b1, 2);
    service(20);
  endtask

  task automatic test_timeout();
    apply_reset();
    gen_silent = 1'b1;
    request(1'b0, 3'b001, 24'hCAFE01, 1'b1, 6'h00, 1'b1, 1'b1, 0);
    service(TIMEOUT + 40);
    checks++;
    if (last_busy_cnt !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_cycles: %0d busy cycles before fault, required %0d", last_busy_cnt, TIMEOUT);
    end
    checks++;
    if (fault_o !== 1'b1) begin
      errors++;
      $display("FAIL fault_set: fault_o=%b, required 1", fault_o);
    end
    gen_silent = 1'b0;
    request(1'b1, 3'b101, 24'h0F0F0F, 1'b0, 6'h00, 1'b1, 1'b1, 2);
    service(20);
    request(1'b0, 3'b010, 24'h00F0F0, 1'b0, 6'h00, 1'b1, 1'b1, 0);
    request(1'b1, 3'b100, 24'h000777, 1'b0, 6'h00, 1'b1, 1'b1, 0);
    service(20);
    checks++;
    if (fault_o !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky: fault_o=%b, required 1", fault_o);
    end
    apply_reset();
    checks++;
    if (fault_o !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: fault_o=%b after reset, required 0", fault_o);
    end
  endtask

  task automatic test_reset_busy();
    gen_silent = 1'b1;
    fast_req_i = 1'b1; fast_mode_i = 3'b001; fast_data_i = 24'h5A5A5A;
    tick();
    tick();
    checks++;
    if (enable_crc_gen_o !== 3'b001) begin
      errors++;
      $display("FAIL busy_enable: enable=%b, required 001", enable_crc_gen_o);
    end
    reset_n_tx = 1'b0;
    tick();
    checks++;
    if (enable_crc_gen_o !== 3'b000 || fast_ack_o || slow_ack_o || fault_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_busy: enable=%b ack=%b%b fault=%b, required 000 00 0",
               enable_crc_gen_o, fast_ack_o, slow_ack_o, fault_o);
    end
    reset_n_tx = 1'b1;
    fast_req_i = 1'b0;
    gen_silent = 1'b0;
    tick();
    gen_crc = 6'h1C; gen_delay = 2;
    request(1'b0, 3'b011, 24'h000ACE, 1'b1, 6'h0C, 1'b0, 1'b1, 1);
    service(50);
  endtask

  initial begin
    reset_n_tx = 1'b0;
    fast_req_i = 1'b0; fast_mode_i = 3'b000; fast_data_i = 24'd0;
    slow_req_i = 1'b0; slow_mode_i = 3'b000; slow_data_i = 24'd0;
    crc_gen_i = 6'd0; crc_gen_done_i = 2'b00;
    test_reset();
    test_basic();
    test_round_robin();
    test_mismatch();
    test_illegal();
    test_timeout();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
